pe_dot_sequencer: RTL and testbench

Front-end and drain controller for one PE MAC. It accepts a stream of (activation, weight) pairs over a valid/ready handshake and clears the PE at the start of each dot-product. It drives the PE operands one pair per accepted beat, with zero bubbles on stalls, and captures the finished accumulator result into a valid/ready output register. It sits directly upstream of the PE and also consumes the PE's o_output.

---
 rtl/pe_dot_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pe_dot_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dot_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : pe_dot_sequencer
// Brief    : Front-end and drain controller for a single PE MAC. Accepts
//            (activation, weight) pairs over valid/ready, clears the PE at the
//            start of every dot-product, feeds one registered operand pair per
//            accepted beat (zero operands on bubbles) and captures the final
//            accumulator value into a valid/ready output register.
// Options  : PE_SEQ_LEN_CHECK_EN - when defined, a vector reaching MAX_LEN pairs
//            without i_last is closed early and flagged on o_overflow.
// Revision : 1.0 - initial release
//==============================================================================
module pe_dot_sequencer #(
    parameter int  BW      = 8,
    parameter int  MAX_LEN = 256,
    localparam int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [BW-1:0]     i_activation,
    input  logic [BW-1:0]     i_weight,
    input  logic              i_last,
    output logic              o_pe_clear,
    output logic [BW-1:0]     o_pe_activation,
    output logic [BW-1:0]     o_pe_weight,
    input  logic [2*BW-1:0]   i_pe_result,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [2*BW-1:0]   o_result,
    output logic [CW-1:0]     o_count,
    output logic              o_overflow
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN1 = 3'd3,
        S_DRAIN2 = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] beat_count;
    logic          beat;
    logic          at_limit;
    logic          vec_end;
    logic          out_accept;

    // Pairs are only taken while feeding; IDLE/CLEAR make the source hold its data.
    assign o_in_ready = (state == S_FEED);
    assign beat       = i_in_valid & o_in_ready;
    assign out_accept = o_out_valid & i_out_ready;

`ifdef PE_SEQ_LEN_CHECK_EN
    // This beat fills the vector to MAX_LEN, so it closes the vector on its own.
    assign at_limit = (beat_count == CW'(MAX_LEN - 1));
`else
    assign at_limit = 1'b0;
`endif

    assign vec_end = beat & (i_last | at_limit);

    // State register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: one clear cycle before feeding, two drain cycles after.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (i_in_valid) next_state = S_CLEAR;
            S_CLEAR:  next_state = S_FEED;
            S_FEED:   if (vec_end) next_state = S_DRAIN1;
            S_DRAIN1: next_state = S_DRAIN2;
            S_DRAIN2: next_state = S_OUT;
            S_OUT:    if (out_accept) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // PE drive: clear is high exactly during CLEAR (and in reset); operands are
    // the accepted pair for one cycle, otherwise zero so the PE adds nothing.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_pe_clear      <= 1'b1;
            o_pe_activation <= '0;
            o_pe_weight     <= '0;
        end else begin
            o_pe_clear      <= (next_state == S_CLEAR);
            o_pe_activation <= beat ? i_activation : '0;
            o_pe_weight     <= beat ? i_weight : '0;
        end
    end

    // Beat counter: restarted in CLEAR, saturates at MAX_LEN.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            beat_count <= '0;
        end else if (state == S_CLEAR) begin
            beat_count <= '0;
        end else if (beat && (beat_count != CW'(MAX_LEN))) begin
            beat_count <= beat_count + 1'b1;
        end
    end

    // Output register: capture in DRAIN2 once the last product is in the
    // accumulator, hold until the consumer takes it.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_out_valid <= 1'b0;
            o_result    <= '0;
            o_count     <= '0;
        end else if (state == S_DRAIN2) begin
            o_out_valid <= 1'b1;
            o_result    <= i_pe_result;
            o_count     <= beat_count;
        end else if ((state == S_OUT) && out_accept) begin
            o_out_valid <= 1'b0;
        end
    end

`ifdef PE_SEQ_LEN_CHECK_EN
    logic limit_hit;

    // Remember whether the vector was closed by the length limit, not by i_last.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            limit_hit <= 1'b0;
        end else if (state == S_CLEAR) begin
            limit_hit <= 1'b0;
        end else if (vec_end) begin
            limit_hit <= ~i_last;
        end
    end

    // Overflow flag travels with the captured result and drops on acceptance.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_overflow <= 1'b0;
        end else if (state == S_DRAIN2) begin
            o_overflow <= limit_hit;
        end else if ((state == S_OUT) && out_accept) begin
            o_overflow <= 1'b0;
        end
    end
`else
    assign o_overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_dot_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_pe_dot_sequencer
// Brief    : Scoreboard bench for pe_dot_sequencer with a behavioural PE MAC,
//            directed vectors and randomized vectors/bubbles/backpressure.
// Revision : 1.0 - initial release
//==============================================================================
module tb_pe_dot_sequencer;

    localparam int BW      = 8;
    localparam int MAX_LEN = 4;
    localparam int CW      = $clog2(MAX_LEN + 1);
    localparam int RW      = 2 * BW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] act;
    logic [BW-1:0] wgt;
    logic          last;
    logic          pe_clear;
    logic [BW-1:0] pe_act;
    logic [BW-1:0] pe_wgt;
    logic [RW-1:0] pe_acc = '0;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] result;
    logic [CW-1:0] count;
    logic          overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stall_left = 0;
    bit rand_ready = 0;

    typedef struct {
        logic [RW-1:0] res;
        logic [CW-1:0] cnt;
        logic          ovf;
    } exp_t;

    exp_t sb[$];
    int   lat_q[$];

    logic [RW-1:0] m_sum = '0;
    int            m_n   = 0;

    pe_dot_sequencer #(.BW(BW), .MAX_LEN(MAX_LEN)) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_in_valid      (in_valid),
        .o_in_ready      (in_ready),
        .i_activation    (act),
        .i_weight        (wgt),
        .i_last          (last),
        .o_pe_clear      (pe_clear),
        .o_pe_activation (pe_act),
        .o_pe_weight     (pe_wgt),
        .i_pe_result     (pe_acc),
        .o_out_valid     (out_valid),
        .i_out_ready     (out_ready),
        .o_result        (result),
        .o_count         (count),
        .o_overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Behavioural PE: clear wins, otherwise multiply-accumulate with wrap.
    always @(posedge clk) begin
        pe_acc <= pe_clear ? '0 : pe_acc + RW'(pe_act) * RW'(pe_wgt);
        cyc    <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_sum = '0;
        m_n   = 0;
        sb.delete();
        lat_q.delete();
    endtask

    // Reference: a vector is the sum of its products; count is its length capped
    // at MAX_LEN; with the length check, hitting MAX_LEN closes the vector.
    task automatic model_beat(input logic [BW-1:0] a, input logic [BW-1:0] w,
                              input bit l, input int beat_cyc);
        exp_t e;
        bit   done;
        bit   ovf;
        m_sum = m_sum + RW'(a) * RW'(w);
        m_n++;
        done = l;
        ovf  = 1'b0;
`ifdef PE_SEQ_LEN_CHECK_EN
        if (m_n == MAX_LEN) begin
            done = 1'b1;
            ovf  = !l;
        end
`endif
        if (done) begin
            e.res = m_sum;
            e.cnt = CW'((m_n > MAX_LEN) ? MAX_LEN : m_n);
            e.ovf = ovf;
            sb.push_back(e);
            lat_q.push_back(beat_cyc + 2);
            m_sum = '0;
            m_n   = 0;
        end
    endtask

    // Present one pair and hold it until the sequencer takes it.
    task automatic send_beat(input logic [BW-1:0] a, input logic [BW-1:0] w, input bit l);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        act      = a;
        wgt      = w;
        last     = l;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", in_ready, 1);
        if (in_ready) begin
            model_beat(a, w, l, cyc + 1);
            @(posedge clk);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // Non-beat cycles with junk on the data lines.
    task automatic bubble(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            act      = 8'($urandom);
            wgt      = 8'($urandom);
            last     = 1'($urandom);
        end
    endtask

    task automatic end_vec();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((sb.size() != 0 || out_valid) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_pe_clear"}, pe_clear, 1);
        check({tag, "_pe_act"},   pe_act, 0);
        check({tag, "_pe_wgt"},   pe_wgt, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_result"},   result, 0);
        check({tag, "_count"},    count, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    // Monitor: drives backpressure, pops the scoreboard on each accepted result,
    // checks latency, hold stability and the one-cycle valid drop.
    initial begin : monitor
        bit            prev_valid  = 1'b0;
        bit            holding     = 1'b0;
        bit            expect_drop = 1'b0;
        bit            rdy;
        logic [RW-1:0] h_res;
        logic [CW-1:0] h_cnt;
        exp_t          e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid  = 1'b0;
                holding     = 1'b0;
                expect_drop = 1'b0;
                out_ready   = 1'b0;
            end else begin
                if (expect_drop) begin
                    check("valid_drop", out_valid, 0);
                    expect_drop = 1'b0;
                end
                if (out_valid) begin
                    check("in_ready_low_while_valid", in_ready, 0);
                    if (!prev_valid) begin
                        if (lat_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_valid: valid rose at cycle %0d, no result expected", cyc);
                        end else begin
                            check("latency", cyc, lat_q.pop_front());
                        end
                    end
                    if (holding) begin
                        check("held_result", result, h_res);
                        check("held_count", count, h_cnt);
                    end
                    if (stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                    end else if (rand_ready) begin
                        rdy = 1'($urandom_range(0, 1));
                    end else begin
                        rdy = 1'b1;
                    end
                    out_ready = rdy;
                    if (rdy) begin
                        holding     = 1'b0;
                        expect_drop = 1'b1;
                        if (sb.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_output: result=%0d count=%0d, none expected", result, count);
                        end else begin
                            e = sb.pop_front();
                            check("result", result, e.res);
                            check("count", count, e.cnt);
                            check("overflow", overflow, e.ovf);
                        end
                    end else begin
                        holding = 1'b1;
                        h_res   = result;
                        h_cnt   = count;
                    end
                end else begin
                    holding   = 1'b0;
                    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        act      = '0;
        wgt      = '0;
        last     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;

        // Four unit products, always-ready consumer.
        for (int i = 0; i < 4; i++) send_beat(8'd1, 8'd1, i == 3);
        end_vec();
        wait_drain();

        // Bubbles inside the vector contribute nothing.
        send_beat(8'd128, 8'd1, 1'b0);
        bubble(1);
        send_beat(8'd128, 8'd2, 1'b0);
        bubble(2);
        send_beat(8'd128, 8'd3, 1'b1);
        end_vec();
        wait_drain();

        // Single full-scale product, then a fresh vector proves the clear.
        send_beat(8'd255, 8'd255, 1'b1);
        end_vec();
        send_beat(8'd2, 8'd3, 1'b1);
        end_vec();
        wait_drain();

        // Consumer stalls for five cycles after valid.
        stall_left = 5;
        send_beat(8'd7, 8'd9, 1'b0);
        send_beat(8'd3, 8'd4, 1'b1);
        end_vec();
        wait_drain();

        // Reset in the middle of a vector discards it.
        send_beat(8'd5, 8'd5, 1'b0);
        send_beat(8'd5, 8'd5, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        model_reset();
        stall_left = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send_beat(8'd1, 8'd2, 1'b1);
        end_vec();
        wait_drain();

        // Six pairs, last on the sixth: exceeds MAX_LEN.
        for (int i = 0; i < 6; i++) send_beat(8'd1, 8'd1, i == 5);
        end_vec();
        wait_drain();

        // Randomized vectors, bubbles and backpressure.
        rand_ready = 1'b1;
        for (int v = 0; v < 40; v++) begin
            n = $urandom_range(1, 7);
            if ($urandom_range(0, 3) == 0) stall_left = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) bubble($urandom_range(1, 2));
                send_beat(8'($urandom), 8'($urandom), i == n - 1);
            end
            end_vec();
            if ($urandom_range(0, 2) == 0) bubble($urandom_range(1, 3));
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
